mux8_rr_arbiter: RTL and testbench
==================================

Name: mux8_rr_arbiter

Overview:
- Round-robin scheduler that shares one 8:1 data path between 8 requesters.
- Each cycle it picks one requester, registers that requester's select code and data word, and presents them downstream with a valid/ready handshake.
- Sits in front of the 8:1 mux datapath and drives its select; also returns a per-requester acknowledge.
- Sustains one transfer per cycle when downstream is always ready.

Parameters:
- NREQ, 8, number of requesters; fixed at 8, so the select is 3 bits.
- DW, 8, data width per requester.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- req  input  NREQ  per-requester request level; must be held until the matching ack.
- d  input  NREQ*DW  packed requester data; requester i occupies d[i*DW +: DW].
- ack  output  NREQ  one-hot, combinational; ack[i] = out_valid & out_ready & (sel == i).
- sel  output  3  registered select code of the current winner; drives the shared mux.
- out_data  output  DW  registered data of the winner.
- out_valid  output  1  out_data and sel are valid.
- out_ready  input  1  downstream accepts when out_valid & out_ready.
- ptr  output  3  current round-robin priority pointer; for debug and coverage.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, sel=0, out_data=0, ptr=0, state=IDLE.
  - ack=0, since out_valid=0.
  - Reset mid-transfer drops the pending word with no ack.
- States: IDLE (out_valid=0) and HOLD (out_valid=1).
- Pick function:
  - Scan req starting at index ptr, upward, wrapping 7->0.
  - The first set bit wins; its index is W.
- IDLE:
  - If req != 0: register sel=W, out_data=d[W], set out_valid=1, go to HOLD.
  - Otherwise stay in IDLE.
  - Latency: req rising in cycle t gives out_valid=1 in cycle t+1.
- HOLD, out_ready=0 (stall):
  - sel, out_data and out_valid are held stable. Changing req or d has no effect.
  - No other requester can pre-empt the held word.
- HOLD, out_ready=1 (handshake):
  - ack[sel] pulses for this cycle.
  - ptr <= sel+1, mod 8, wrapping 7->0.
  - Re-arbitrate the same cycle, using pointer sel+1 and req with bit sel masked off. The requester may still show req in its ack cycle.
  - If the masked req is non-zero: load the new winner and stay in HOLD (back-to-back, no bubble).
  - Otherwise: out_valid <= 0 and go to IDLE.
- ptr changes only on a handshake, never on a stall.
- Fairness: with all 8 req held high, the grant order is 0,1,...,7,0. Any continuously requesting input is granted within 8 handshakes.
- req withdrawn before ack:
  - Once captured, the transfer still completes.
  - If not yet captured, the request is simply not seen.
- Single requester re-requesting continuously: because of the mask, it gets every other cycle at best (valid, gap, valid).
- d is sampled only in the cycle the word is loaded.

Optional Feature:
- Macro: MUX8_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. The scan always starts at index 0, so the lowest set index wins. ptr is held at 0 and still resets to 0. The self-mask on handshake is still applied.
- Undefined (default): round-robin as described above.

Decomposition:
- Package mux8_arb_pkg:
  - NREQ=8, SEL_W=3.
  - typedef sel_t (logic [SEL_W-1:0]).
  - State enum arb_state_e {ARB_IDLE, ARB_HOLD}.
- Sub-module rr_pick8 (combinational):
  - Inputs: req[7:0], start[2:0].
  - Outputs: any, win[2:0].
  - Used in both IDLE and the HOLD handshake path.
- Top module: state register, output registers, pointer, ack decode, data slice.

Test Plan:
- Reset, then req=8'h00 for 5 cycles -> out_valid=0, ack=0, sel=0, ptr=0 throughout.
- req=8'h10 with d[4]=8'hA5, out_ready=1 -> next cycle sel=4, out_data=8'hA5, ack=8'h10; then ptr=5 and out_valid=0 after req drops.
- req=8'hFF held, out_ready=1, d[i]=i -> sel and out_data sequence 0,1,...,7,0 on consecutive cycles with no bubbles; ack is one-hot each cycle.
- req=8'h81 with ptr=1, out_ready=0 for 3 cycles -> sel=7 stable, ack=0, ptr=1; raise out_ready -> ack=8'h80, then sel=0 the next cycle.
- Assert rst during HOLD with out_ready=0 -> next cycle out_valid=0, ptr=0, no ack issued.
- With MUX8_ARB_FIXED_PRIO_EN defined, req=8'h06 held -> sel alternates 1,2,1,2 (self-mask) and ptr stays 0.

Source files
------------

// File: rtl/mux8_arb_pkg.sv
// Shared types for the 8-way round-robin arbiter in front of the 8:1 mux datapath.
package mux8_arb_pkg;

  localparam int unsigned NREQ  = 8;
  localparam int unsigned SEL_W = 3;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_HOLD
  } arb_state_e;

endpackage

// File: rtl/rr_pick8.sv
// Combinational 8-way picker: scans req upward from start (wrapping 7->0), first set bit wins.
module rr_pick8
  import mux8_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  sel_t            start,
  output logic            any,
  output sel_t            win
);

  sel_t idx;

  always_comb begin
    any = 1'b0;
    win = '0;
    idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = start + sel_t'(i);
      if (!any && req[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin scheduler sharing one 8:1 data path; registered sel/data with valid/ready.
// MUX8_ARB_FIXED_PRIO_EN: fixed priority (scan from 0, ptr held at 0).
module mux8_rr_arbiter #(
  parameter int unsigned NREQ = 8,
  parameter int unsigned DW   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   d,
  output logic [NREQ-1:0]      ack,
  output logic [2:0]           sel,
  output logic [DW-1:0]        out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           ptr
);

  import mux8_arb_pkg::*;

  arb_state_e       state_q, state_d;
  sel_t             sel_q, sel_d;
  sel_t             ptr_q, ptr_d;
  logic [DW-1:0]    data_q, data_d;

  logic             hold;
  logic             hs;
  sel_t             sel_inc;
  sel_t             start;
  logic [NREQ-1:0]  sel_oh;
  logic [NREQ-1:0]  pick_req;
  logic             any;
  sel_t             win;

  assign hold    = (state_q == ARB_HOLD);
  assign hs      = hold & out_ready;
  assign sel_inc = sel_q + sel_t'(1);

  always_comb begin
    sel_oh        = '0;
    sel_oh[sel_q] = 1'b1;
  end

  // In HOLD the picker only matters on a handshake: the current winner is
  // masked out and the scan restarts just past it, giving back-to-back grants.
`ifdef MUX8_ARB_FIXED_PRIO_EN
  assign start = '0;
`else
  assign start = hold ? sel_inc : ptr_q;
`endif
  assign pick_req = hold ? (req & ~sel_oh) : req;

  rr_pick8 u_pick (
    .req   (pick_req),
    .start (start),
    .any   (any),
    .win   (win)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    case (state_q)
      ARB_IDLE: begin
        if (any) begin
          sel_d   = win;
          data_d  = d[int'(win)*DW +: DW];
          state_d = ARB_HOLD;
        end
      end
      ARB_HOLD: begin
        if (out_ready) begin
`ifndef MUX8_ARB_FIXED_PRIO_EN
          ptr_d = sel_inc;
`endif
          if (any) begin
            sel_d  = win;
            data_d = d[int'(win)*DW +: DW];
          end else begin
            state_d = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
    end
  end

  assign ack       = hs ? sel_oh : '0;
  assign sel       = sel_q;
  assign out_data  = data_q;
  assign out_valid = hold;
  assign ptr       = ptr_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: per-cycle reference model plus directed literal checks.
module tb_mux8_rr_arbiter;

`ifdef MUX8_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  req;
  logic [63:0] d;
  logic [7:0]  ack;
  logic [2:0]  sel;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  ptr;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  mux8_rr_arbiter #(.NREQ(8), .DW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .d         (d),
    .ack       (ack),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ptr       (ptr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the next winner is the first requesting index found
  // walking upward from the start position, modulo 8.
  int m_valid = 0;
  int m_sel   = 0;
  int m_data  = 0;
  int m_ptr   = 0;

  function automatic int pick(input logic [7:0] r, input int s);
    for (int k = 0; k < 8; k++) begin
      if (r[(s + k) % 8]) return (s + k) % 8;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    int st;
    logic [7:0] mr;
    if (rst) begin
      m_valid = 0; m_sel = 0; m_data = 0; m_ptr = 0;
    end else if (m_valid == 0) begin
      st = FIXED ? 0 : m_ptr;
      w  = pick(req, st);
      if (w >= 0) begin
        m_sel = w; m_data = int'(d[w*8 +: 8]); m_valid = 1;
      end
    end else if (out_ready) begin
      mr = req;
      mr[m_sel] = 1'b0;
      st = FIXED ? 0 : (m_sel + 1) % 8;
      if (!FIXED) m_ptr = (m_sel + 1) % 8;
      w = pick(mr, st);
      if (w >= 0) begin
        m_sel = w; m_data = int'(d[w*8 +: 8]);
      end else begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("mdl_valid", 32'(out_valid), 32'(m_valid));
      chk("mdl_ptr", 32'(ptr), 32'(m_ptr));
      chk("mdl_ack", 32'(ack), (m_valid != 0 && out_ready) ? (32'd1 << m_sel) : 32'd0);
      if (m_valid != 0) begin
        chk("mdl_sel", 32'(sel), 32'(m_sel));
        chk("mdl_data", 32'(out_data), 32'(m_data));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; req = '0; d = '0; out_ready = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
    started = 1'b1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_ptr", 32'(ptr), 0);
    chk("rst_ack", 32'(ack), 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("idle_valid", 32'(out_valid), 0);
      chk("idle_ack", 32'(ack), 0);
      chk("idle_sel", 32'(sel), 0);
      chk("idle_ptr", 32'(ptr), 0);
    end

`ifndef MUX8_ARB_FIXED_PRIO_EN
    // single request on input 4
    d[39:32] = 8'hA5; req = 8'h10; out_ready = 1'b1;
    cyc();
    chk("r4_sel", 32'(sel), 4);
    chk("r4_data", 32'(out_data), 32'hA5);
    chk("r4_valid", 32'(out_valid), 1);
    chk("r4_ack", 32'(ack), 32'h10);
    chk("r4_ptr", 32'(ptr), 0);
    req = '0;
    cyc();
    chk("r4_done_valid", 32'(out_valid), 0);
    chk("r4_done_ptr", 32'(ptr), 5);
    chk("r4_done_ack", 32'(ack), 0);

    // all requesting: grant order 0..7,0 with no bubbles
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) d[i*8 +: 8] = 8'(i);
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      cyc();
      chk("all_valid", 32'(out_valid), 1);
      chk("all_sel", 32'(sel), k % 8);
      chk("all_data", 32'(out_data), k % 8);
      chk("all_ack", 32'(ack), 32'd1 << (k % 8));
    end
    req = '0;
    cyc();
    chk("all_end_valid", 32'(out_valid), 0);
    chk("all_end_ptr", 32'(ptr), 1);

    // wrap from ptr=1 to index 7, stall, then hand over to 0
    req = 8'h81; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("stall_sel", 32'(sel), 7);
      chk("stall_data", 32'(out_data), 7);
      chk("stall_ack", 32'(ack), 0);
      chk("stall_ptr", 32'(ptr), 1);
      d[56 +: 8] = 8'hEE;
    end
    out_ready = 1'b1;
    #1;
    chk("stall_rel_ack", 32'(ack), 32'h80);
    cyc();
    chk("after_stall_sel", 32'(sel), 0);
    chk("after_stall_ptr", 32'(ptr), 0);
    chk("after_stall_ack", 32'(ack), 32'h01);

    // reset during a stalled HOLD drops the word
    out_ready = 1'b0; rst = 1'b1;
    cyc();
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_ptr", 32'(ptr), 0);
    chk("mid_rst_ack", 32'(ack), 0);
    rst = 1'b0; req = '0;
    cyc();

    // a lone continuous requester gets every other cycle
    req = 8'h04; out_ready = 1'b1;
    cyc();
    chk("lone_v0", 32'(out_valid), 1);
    chk("lone_sel0", 32'(sel), 2);
    cyc();
    chk("lone_v1", 32'(out_valid), 0);
    chk("lone_ptr1", 32'(ptr), 3);
    cyc();
    chk("lone_v2", 32'(out_valid), 1);
    chk("lone_sel2", 32'(sel), 2);
    req = '0;
    cyc();
`else
    // fixed priority with self-mask: 1,2,1,2
    req = 8'h06; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("fix_sel", 32'(sel), (k % 2 == 0) ? 1 : 2);
      chk("fix_ptr", 32'(ptr), 0);
      chk("fix_valid", 32'(out_valid), 1);
    end
    req = '0;
    cyc();
`endif

    // mixed traffic, checked by the model only
    for (int k = 0; k < 300; k++) begin
      req       = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      d         = {$urandom, $urandom};
      rst       = ($urandom_range(0, 63) == 0);
      cyc();
    end
    rst = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
